uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter W, default 8, data bits per frame (5..9).
REQ-002 Parameter STOP, default 1, stop bits per frame (1 or 2).
REQ-003 Parameter PAR, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port tick  input  1  bit-period strobe, one clk wide, from the clock divider stage.
REQ-007 Port data  input  W  parallel word to send.
REQ-008 Port valid  input  1  data is valid.
REQ-009 Port ready  output  1  block can accept a word.
REQ-010 Port busy  output  1  frame in progress (any state except IDLE).
REQ-011 Port txd  output  1  serial line, idle high.

Function
REQ-012 States SHALL be IDLE, SYNC, START, DATA, PARITY, STOP.
REQ-013 ready SHALL be 1 only in IDLE; a transfer SHALL occur on a clk edge with valid=1 and ready=1.
REQ-014 On transfer: data latched into shift register, state -> SYNC, ready=0 from next cycle.
REQ-015 valid without ready SHALL be ignored; data need not be held after transfer.
REQ-016 tick SHALL be ignored in IDLE, including a tick coincident with the transfer edge.
REQ-017 SYNC: txd=1; on next tick -> START.
REQ-018 START: txd=0; on tick -> DATA, bit counter cleared.
REQ-019 DATA: txd = shift register LSB; on tick shift right, counter+1; after W ticks -> PARITY if PAR!=0, else STOP.
REQ-020 PARITY: txd = XOR of latched word (even) or its inverse (odd); on tick -> STOP.
REQ-021 STOP: txd=1 for STOP ticks; on last tick -> IDLE, ready=1 next cycle.
REQ-022 Every transmitted bit SHALL last exactly one tick-to-tick interval; txd changes only on the clk edge sampling tick=1.
REQ-023 tick held constantly high SHALL yield one clk per bit, with no lost or extra bits.
REQ-024 Back-to-back: valid held high SHALL start the next frame via SYNC, with no more than one idle tick interval between frames.
REQ-025 txd SHALL be registered; no combinational path from any input to txd.
REQ-026 Counters sized $clog2(W+1) and $clog2(STOP+1); no wrap inside a frame.
REQ-027 Illegal parameter values SHALL stop elaboration with an error.

Reset
REQ-028 With rst_n=0: txd=1, ready=0, busy=0, state IDLE, counters and shift register 0, all asynchronously.
REQ-029 Reset mid-frame SHALL abort the frame; txd=1 immediately; no partial frame resumes.
REQ-030 ready SHALL rise on the first clk edge after rst_n deasserts.

Structure
REQ-031 The shared package SHALL hold the state enumeration and the parity-mode constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2).
REQ-032 The block SHALL be a single module with no sub-module; tick comes from a clkdiv instance at the integrating level.

Verification
REQ-033 W=8, PAR=0, STOP=1, tick every 5 clk; send 0xA5 -> txd bits 0,1,0,1,0,0,1,0,1,1, each 5 clk; ready returns after the stop bit.
REQ-034 PAR=2, send 0xA5 -> parity bit 0; PAR=1 -> parity bit 1; frame is 11 bits.
REQ-035 valid held high with words 0x00, 0xFF -> two frames, start bits separated by at most 11 tick intervals, both words correct.
REQ-036 Reset asserted during data bit 3 -> txd=1 within the same cycle, busy=0; after release, 0x3C sent correctly.
REQ-037 tick tied high, STOP=2 -> frame of 11 clk bits plus 1 SYNC clk; tick coincident with transfer -> no shortened start bit.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter: state encoding,
// parity-mode selectors and the parity helper.
package uart_tx_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // Word is zero-extended to 9 bits by the caller; zero padding leaves the XOR unchanged.
  function automatic logic parity_bit(input int unsigned mode, input logic [8:0] word);
    return (mode == PAR_ODD) ? ~(^word) : (^word);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Word handshake between a producer and the UART transmitter.
interface uart_tx_if #(
  parameter int unsigned W = 8
);

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word over a valid/ready handshake and serialises it
// on txd as start, W data bits (LSB first), optional parity and STOP stop bits.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter int unsigned STOP = 1,
  parameter int unsigned PAR  = PAR_NONE
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     tick,
  uart_tx_if.slave bus,
  output logic     busy,
  output logic     txd
);

  if ((W < 5) || (W > 9)) begin : g_bad_w
    $error("uart_tx: W must be in 5..9");
  end
  if ((STOP < 1) || (STOP > 2)) begin : g_bad_stop
    $error("uart_tx: STOP must be 1 or 2");
  end
  if (PAR > PAR_EVEN) begin : g_bad_par
    $error("uart_tx: PAR must be 0, 1 or 2");
  end

  localparam int unsigned CntW  = $clog2(W + 1);
  localparam int unsigned StopW = $clog2(STOP + 1);

  state_e             state_q, state_d;
  logic [W-1:0]       shift_q, shift_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [StopW-1:0]   stop_q, stop_d;
  logic               par_q, par_d;
  logic               ready_q, ready_d;
  logic               txd_q, txd_d;
  logic               xfer;

  assign xfer = bus.valid & ready_q;

  // Next-state logic; tick is deliberately not consulted in StIdle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    par_d   = par_q;

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          shift_d = bus.data;
          par_d   = parity_bit(PAR, 9'(bus.data));
          state_d = StSync;
        end
      end
      StSync: begin
        if (tick) state_d = StStart;
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          cnt_d   = '0;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CntW'(W - 1)) begin
            state_d = (PAR != PAR_NONE) ? StParity : StStop;
            stop_d  = '0;
          end
        end
      end
      StParity: begin
        if (tick) begin
          state_d = StStop;
          stop_d  = '0;
        end
      end
      StStop: begin
        if (tick) begin
          if (stop_q == StopW'(STOP - 1)) begin
            state_d = StIdle;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level and ready are derived from the upcoming state so both are registered.
  always_comb begin
    ready_d = (state_d == StIdle);
    txd_d   = 1'b1;
    unique case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shift_d[0];
      StParity: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      stop_q  <= '0;
      par_q   <= 1'b0;
      ready_q <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      ready_q <= ready_d;
      txd_q   <= txd_d;
    end
  end

  assign bus.ready = ready_q;
  assign busy      = (state_q != StIdle);
  assign txd       = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameterisations share clock and reset;
// each serial frame is sampled on every falling edge and compared bit by bit.
module tb_uart_tx;
  import uart_tx_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One-clk tick every 5 clk, standing in for the clock divider.
  int   tick_cnt = 0;
  logic tick5;
  always @(posedge clk) tick_cnt <= (tick_cnt == 4) ? 0 : tick_cnt + 1;
  assign tick5 = (tick_cnt == 4);

  int checks = 0;
  int errors = 0;

  uart_tx_if #(.W(8)) bus0 ();
  uart_tx_if #(.W(8)) bus1 ();
  uart_tx_if #(.W(8)) bus2 ();
  uart_tx_if #(.W(8)) bus3 ();

  wire [3:0] txd_all;
  wire [3:0] busy_all;

  uart_tx #(.W(8), .STOP(1), .PAR(PAR_NONE)) u_d0 (
    .clk(clk), .rst_n(rst_n), .tick(tick5), .bus(bus0), .busy(busy_all[0]), .txd(txd_all[0])
  );
  uart_tx #(.W(8), .STOP(1), .PAR(PAR_ODD)) u_d1 (
    .clk(clk), .rst_n(rst_n), .tick(tick5), .bus(bus1), .busy(busy_all[1]), .txd(txd_all[1])
  );
  uart_tx #(.W(8), .STOP(1), .PAR(PAR_EVEN)) u_d2 (
    .clk(clk), .rst_n(rst_n), .tick(tick5), .bus(bus2), .busy(busy_all[2]), .txd(txd_all[2])
  );
  uart_tx #(.W(8), .STOP(2), .PAR(PAR_NONE)) u_d3 (
    .clk(clk), .rst_n(rst_n), .tick(1'b1), .bus(bus3), .busy(busy_all[3]), .txd(txd_all[3])
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [1:0] d, input logic v, input logic [7:0] dat);
    case (d)
      2'd0: begin bus0.valid = v; bus0.data = dat; end
      2'd1: begin bus1.valid = v; bus1.data = dat; end
      2'd2: begin bus2.valid = v; bus2.data = dat; end
      default: begin bus3.valid = v; bus3.data = dat; end
    endcase
  endtask

  function automatic logic [3:0] readies();
    return {bus3.ready, bus2.ready, bus1.ready, bus0.ready};
  endfunction

  // Called at a falling edge: present one word for exactly one rising edge.
  task automatic send(input logic [1:0] d, input logic [7:0] dat);
    drive(d, 1'b1, dat);
    @(negedge clk);
    drive(d, 1'b0, 8'h00);
  endtask

  // Waits for the start bit, then requires each frame bit to hold for exactly
  // 'period' falling-edge samples. bits[i] is frame bit i (bit 0 = start).
  task automatic capture(input logic [1:0] d, input int period, input int nbits,
                         input logic [15:0] bits, input string tag,
                         output int start_cyc, output int wait_n);
    int   t;
    logic s;
    logic obs;
    t = 0;
    while (txd_all[d] !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    wait_n    = t;
    start_cyc = cyc;
    chk({tag, "_start"}, 16'(txd_all[d]), 16'h0);
    if (txd_all[d] !== 1'b0) return;
    for (int b = 0; b < nbits; b++) begin
      obs = 1'bx;
      for (int k = 0; k < period; k++) begin
        if (b != 0 || k != 0) @(negedge clk);
        s = txd_all[d];
        if (k == 0 || s !== bits[b]) obs = s;
      end
      chk($sformatf("%s_bit%0d", tag, b), 16'(obs), 16'(bits[b]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s1, s2, w, t;
    for (int i = 0; i < 4; i++) drive(2'(i), 1'b0, 8'h00);

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", 16'(txd_all), 16'h000F);
    chk("rst_busy", 16'(busy_all), 16'h0000);
    chk("rst_ready", 16'(readies()), 16'h0000);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 16'(readies()), 16'h0000);
    @(negedge clk);
    chk("ready_after_rst", 16'(readies()), 16'h000F);

    // 0xA5, no parity, one stop bit
    send(2'd0, 8'hA5);
    chk("d0_ready_low", 16'(bus0.ready), 16'h0);
    chk("d0_busy", 16'(busy_all[0]), 16'h1);
    capture(2'd0, 5, 10, 16'h034A, "d0_a5", s1, w);
    @(negedge clk);
    chk("d0_ready_back", 16'(bus0.ready), 16'h1);
    chk("d0_idle", 16'(busy_all[0]), 16'h0);

    // Even parity: parity bit 0
    send(2'd2, 8'hA5);
    capture(2'd2, 5, 11, 16'h054A, "d2_even", s1, w);
    @(negedge clk);
    chk("d2_ready_back", 16'(bus2.ready), 16'h1);

    // Odd parity: parity bit 1
    send(2'd1, 8'hA5);
    capture(2'd1, 5, 11, 16'h074A, "d1_odd", s1, w);
    @(negedge clk);
    chk("d1_ready_back", 16'(bus1.ready), 16'h1);

    // tick tied high, two stop bits: one SYNC clk, then one clk per bit
    send(2'd3, 8'hA5);
    chk("d3_busy", 16'(busy_all[3]), 16'h1);
    capture(2'd3, 1, 11, 16'h074A, "d3_fast", s1, w);
    chk("d3_sync_len", 16'(w), 16'h1);
    @(negedge clk);
    chk("d3_ready_back", 16'(bus3.ready), 16'h1);

    // Back-to-back with valid held high
    drive(2'd0, 1'b1, 8'h00);
    @(negedge clk);
    drive(2'd0, 1'b1, 8'hFF);
    capture(2'd0, 5, 10, 16'h0200, "b2b_00", s1, w);
    t = 0;
    while (bus0.ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    drive(2'd0, 1'b0, 8'h00);
    capture(2'd0, 5, 10, 16'h03FE, "b2b_ff", s2, w);
    chk("b2b_gap_le_55clk", 16'((s2 - s1) <= 55), 16'h1);
    @(negedge clk);
    chk("b2b_ready_back", 16'(bus0.ready), 16'h1);

    // Reset during data bit 3, then a clean frame
    send(2'd0, 8'h00);
    t = 0;
    while (txd_all[0] !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (22) @(negedge clk);
    chk("mid_bit3_low", 16'(txd_all[0]), 16'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_txd", 16'(txd_all[0]), 16'h1);
    chk("mid_rst_busy", 16'(busy_all[0]), 16'h0);
    chk("mid_rst_ready", 16'(bus0.ready), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerst_ready", 16'(bus0.ready), 16'h1);
    chk("rerst_txd", 16'(txd_all[0]), 16'h1);
    send(2'd0, 8'h3C);
    capture(2'd0, 5, 10, 16'h0278, "d0_3c", s1, w);
    @(negedge clk);
    chk("d0_3c_ready", 16'(bus0.ready), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
